// File: rtl/edge_row_cache_if.sv
// Query/response and block-RAM read handshake between the relaxation logic, the row cache and memory.
// slave = the cache side; master = requester plus memory side.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

interface edge_row_cache_if #(
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
  logic                   query_enable;
  logic [INDEX_WIDTH-1:0] from_node;
  logic [INDEX_WIDTH-1:0] to_node;
  logic                   flush;
  logic                   ready;
  logic [VALUE_WIDTH-1:0] edge_value;
  logic                   error;
  logic [15:0]            hit_count;
  logic [15:0]            miss_count;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic                   mem_read_enable;
  logic                   mem_read_ready;

  modport master (
    output query_enable, from_node, to_node, flush, mem_read_data, mem_read_ready,
    input  ready, edge_value, error, hit_count, miss_count, mem_addr, mem_read_enable
  );

  modport slave (
    input  query_enable, from_node, to_node, flush, mem_read_data, mem_read_ready,
    output ready, edge_value, error, hit_count, miss_count, mem_addr, mem_read_enable
  );
endinterface

// File: rtl/edge_row_cache.sv
// LINES-entry cache of adjacency-matrix rows; hits answer in 1 cycle, misses fetch the whole row.
// Memory beats wait on mem_read_ready; query_enable is ignored while a fill is in flight.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_row_cache #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int LINES       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  edge_row_cache_if.slave        bus
);
  localparam int CW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [MADDR_WIDTH-1:0] STRIDE = MADDR_WIDTH'(MADDR_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESPOND} state_t;

  state_t                 state;
  logic [MADDR_WIDTH-1:0] base_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [LINES-1:0]       valid_q;
  logic [INDEX_WIDTH-1:0] tag_q  [LINES];
  logic [VALUE_WIDTH-1:0] line_q [LINES][MAX_NODES];
  logic [LW-1:0]          ptr_q, victim_q;
  logic [INDEX_WIDTH-1:0] row_q, col_q, to_q;
  logic                   flush_pend;

  logic                   hit, any_invalid, out_of_range, flush_now, last_col;
  logic [LW-1:0]          hit_idx, victim;
  logic [MADDR_WIDTH-1:0] fill_addr;
  logic [VALUE_WIDTH-1:0] hit_word, resp_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Configuration is captured only while reset is held, and survives the async clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      base_q <= base_address;
      n_q    <= number_of_nodes;
    end
  end

  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    any_invalid = 1'b0;
    victim      = ptr_q;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && tag_q[i] == bus.from_node && !hit) begin
        hit     = 1'b1;
        hit_idx = LW'(i);
      end
    end
    // Descending scan so the lowest-index invalid line wins.
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim      = LW'(i);
        any_invalid = 1'b1;
      end
    end
  end

  assign out_of_range = (bus.from_node >= n_q) || (bus.to_node >= n_q);
  assign flush_now    = flush_pend || bus.flush;
  assign last_col     = (col_q == n_q - INDEX_WIDTH'(1));
  assign fill_addr    = base_q + (MADDR_WIDTH'(row_q) * MADDR_WIDTH'(n_q) + MADDR_WIDTH'(col_q)) * STRIDE;
  assign hit_word     = line_q[hit_idx][bus.to_node[CW-1:0]];
  assign resp_word    = line_q[victim_q][to_q[CW-1:0]];

  generate
    if (MDATA_WIDTH > VALUE_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus.mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];
    end
  endgenerate

  // Line data and tags are qualified by valid_q, so they need no reset.
  always_ff @(posedge clock) begin
    if (state == FILL_WAIT && bus.mem_read_ready) begin
      line_q[victim_q][col_q[CW-1:0]] <= bus.mem_read_data[VALUE_WIDTH-1:0];
      tag_q[victim_q]                 <= row_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      valid_q             <= '0;
      ptr_q               <= '0;
      victim_q            <= '0;
      row_q               <= '0;
      col_q               <= '0;
      to_q                <= '0;
      flush_pend          <= 1'b0;
      bus.ready           <= 1'b0;
      bus.error           <= 1'b0;
      bus.edge_value      <= '0;
      bus.mem_addr        <= '0;
      bus.mem_read_enable <= 1'b0;
      bus.hit_count       <= '0;
      bus.miss_count      <= '0;
    end else begin
      bus.ready <= 1'b0;
      bus.error <= 1'b0;
      if (bus.flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_now) begin
            valid_q    <= '0;
            ptr_q      <= '0;
            flush_pend <= 1'b0;
          end else if (bus.query_enable) begin
            row_q <= bus.from_node;
            to_q  <= bus.to_node;
            if (out_of_range) begin
              bus.ready      <= 1'b1;
              bus.error      <= 1'b1;
              bus.edge_value <= '0;
            end else if (hit) begin
              bus.ready      <= 1'b1;
              bus.edge_value <= hit_word;
              bus.hit_count  <= sat_inc(bus.hit_count);
            end else begin
              bus.miss_count  <= sat_inc(bus.miss_count);
              victim_q        <= victim;
              valid_q[victim] <= 1'b0;
              col_q           <= '0;
              if (!any_invalid)
                ptr_q <= (ptr_q == LW'(LINES - 1)) ? '0 : ptr_q + LW'(1);
              state <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          bus.mem_addr        <= fill_addr;
          bus.mem_read_enable <= 1'b1;
          state               <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (bus.mem_read_ready) begin
            bus.mem_read_enable <= 1'b0;
            if (last_col) begin
              valid_q[victim_q] <= 1'b1;
              state             <= RESPOND;
            end else begin
              col_q <= col_q + INDEX_WIDTH'(1);
              state <= FILL_REQ;
            end
          end
        end
        RESPOND: begin
          bus.ready      <= 1'b1;
          bus.edge_value <= resp_word;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_row_cache.sv
// Directed table plus randomized queries against a row-level cache model; memory returns 256*r+c+1.
module tb_edge_row_cache;
  localparam int          N      = 14;
  localparam logic [31:0] BASE   = 32'h34;
  localparam int          STRIDE = 4;
  localparam int          NL     = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] base_address = BASE;
  logic [7:0]  number_of_nodes = 8'(N);

  edge_row_cache_if bus ();

  edge_row_cache dut (
    .clock           (clock),
    .reset           (reset),
    .base_address    (base_address),
    .number_of_nodes (number_of_nodes),
    .bus             (bus)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] grants[$];
  int          stall = 0;
  int          max_stall = 2;
  int          grant_limit = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) / STRIDE);
    return {16'hDEAD, 16'(256 * (idx / N) + idx % N + 1)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: answers each read after a random wait, one beat per request.
  always @(posedge clock) begin
    #1;
    if (bus.mem_read_ready) bus.mem_read_ready = 1'b0;
    else if (reset && bus.mem_read_enable && (grant_limit < 0 || grants.size() < grant_limit)) begin
      if (stall > 0) stall--;
      else begin
        bus.mem_read_data  = mem_word(bus.mem_addr);
        bus.mem_read_ready = 1'b1;
        grants.push_back(bus.mem_addr);
        stall = $urandom_range(0, max_stall);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    base_address    = BASE;
    number_of_nodes = 8'(N);
    reset = 1'b0;
    #1;
    check("rst.ready", 32'(bus.ready), 0);
    check("rst.error", 32'(bus.error), 0);
    check("rst.edge_value", 32'(bus.edge_value), 0);
    check("rst.mem_read_enable", 32'(bus.mem_read_enable), 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.hit_count", 32'(bus.hit_count), 0);
    check("rst.miss_count", 32'(bus.miss_count), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    // Config must be ignored once reset is released.
    base_address    = 32'hFFFF_0000;
    number_of_nodes = 8'd3;
  endtask

  task automatic run_query(input int f, input int t, input bit fl,
                           output logic [15:0] v, output logic e, output int lat);
    grants.delete();
    @(negedge clock);
    bus.from_node    = 8'(f);
    bus.to_node      = 8'(t);
    bus.query_enable = 1'b1;
    @(negedge clock);
    bus.query_enable = 1'b0;
    bus.flush        = fl;
    lat = 1;
    while (!bus.ready && lat < 3000) begin
      @(negedge clock);
      bus.flush = 1'b0;
      lat++;
    end
    if (!bus.ready) check("ready_timeout", 0, 1);
    v = bus.edge_value;
    e = bus.error;
    @(negedge clock);
    bus.flush = 1'b0;
    check("ready_single_pulse", 32'(bus.ready), 0);
  endtask

  task automatic txn(input string tag, input int f, input int t, input bit fl,
                     input logic [15:0] exp_v, input bit exp_e, input bit exp_miss,
                     input int exp_h, input int exp_m);
    logic [15:0] v;
    logic        e;
    int          lat;
    int          addr_bad;
    run_query(f, t, fl, v, e, lat);
    check({tag, ".edge_value"}, 32'(v), 32'(exp_v));
    check({tag, ".error"}, 32'(e), 32'(exp_e));
    check({tag, ".hit_count"}, 32'(bus.hit_count), 32'(exp_h));
    check({tag, ".miss_count"}, 32'(bus.miss_count), 32'(exp_m));
    check({tag, ".reads"}, grants.size(), exp_miss ? N : 0);
    if (exp_miss && grants.size() == N) begin
      addr_bad = 0;
      for (int c = 0; c < N; c++)
        if (grants[c] !== BASE + 32'((f * N + c) * STRIDE)) addr_bad++;
      check({tag, ".addr_seq_errors"}, addr_bad, 0);
    end
    if (!exp_miss) check({tag, ".latency"}, lat, 1);
  endtask

  typedef struct {
    bit          rst;
    int          f;
    int          t;
    logic [15:0] v;
    bit          e;
    bit          miss;
    int          h;
    int          m;
  } vec_t;

  vec_t tbl[13];

  bit mv[NL];
  int mt[NL];
  int mp, mh, mm;

  initial begin
    bus.query_enable   = 1'b0;
    bus.from_node      = '0;
    bus.to_node        = '0;
    bus.flush          = 1'b0;
    bus.mem_read_data  = '0;
    bus.mem_read_ready = 1'b0;

    tbl[0]  = '{1, 2, 5,  16'h206, 0, 1, 0, 1};
    tbl[1]  = '{0, 2, 9,  16'h20A, 0, 0, 1, 1};
    tbl[2]  = '{0, 14, 0, 16'h000, 1, 0, 1, 1};
    tbl[3]  = '{0, 2, 14, 16'h000, 1, 0, 1, 1};
    tbl[4]  = '{1, 0, 0,  16'h001, 0, 1, 0, 1};
    tbl[5]  = '{0, 1, 13, 16'h10E, 0, 1, 0, 2};
    tbl[6]  = '{0, 2, 0,  16'h201, 0, 1, 0, 3};
    tbl[7]  = '{0, 3, 7,  16'h308, 0, 1, 0, 4};
    tbl[8]  = '{0, 4, 4,  16'h405, 0, 1, 0, 5};
    tbl[9]  = '{0, 1, 1,  16'h102, 0, 0, 1, 5};
    tbl[10] = '{0, 0, 0,  16'h001, 0, 1, 1, 6};
    tbl[11] = '{0, 1, 1,  16'h102, 0, 1, 1, 7};
    tbl[12] = '{0, 3, 13, 16'h30E, 0, 0, 2, 7};

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      txn($sformatf("vec%0d", i), tbl[i].f, tbl[i].t, 1'b0, tbl[i].v, tbl[i].e,
          tbl[i].miss, tbl[i].h, tbl[i].m);
    end

    // Back-to-back hits: lines now hold rows 4, 0, 1, 3.
    @(negedge clock);
    bus.from_node = 8'd4; bus.to_node = 8'd2; bus.query_enable = 1'b1;
    @(negedge clock);
    check("b2b.first_ready", 32'(bus.ready), 1);
    check("b2b.first_value", 32'(bus.edge_value), 32'h403);
    bus.from_node = 8'd0; bus.to_node = 8'd3;
    @(negedge clock);
    bus.query_enable = 1'b0;
    check("b2b.second_ready", 32'(bus.ready), 1);
    check("b2b.second_value", 32'(bus.edge_value), 32'h004);
    @(negedge clock);
    check("b2b.ready_low", 32'(bus.ready), 0);
    check("b2b.hit_count", 32'(bus.hit_count), 4);

    // Reset during the 7th beat of a row-3 fill.
    do_reset();
    grants.delete();
    grant_limit = 6;
    @(negedge clock);
    bus.from_node = 8'd3; bus.to_node = 8'd3; bus.query_enable = 1'b1;
    @(negedge clock);
    bus.query_enable = 1'b0;
    for (int k = 0; k < 2000 && !(grants.size() == 6 && bus.mem_read_enable); k++)
      @(negedge clock);
    check("midfill.beats_done", grants.size(), 6);
    check("midfill.enable_before", 32'(bus.mem_read_enable), 1);
    check("midfill.miss_before", 32'(bus.miss_count), 1);
    do_reset();
    grant_limit = -1;
    txn("after_rst", 3, 3, 1'b0, 16'h304, 0, 1, 0, 1);

    // Flush during a fill: current response completes, the row is then gone.
    txn("flush_fill", 1, 2, 1'b1, 16'h103, 0, 1, 0, 2);
    txn("flush_after", 1, 2, 1'b0, 16'h103, 0, 1, 0, 3);

    // Randomized traffic against a row-level model.
    do_reset();
    for (int j = 0; j < NL; j++) begin mv[j] = 0; mt[j] = 0; end
    mp = 0; mh = 0; mm = 0;
    for (int i = 0; i < 200; i++) begin
      int  f, t, v, hitl;
      bit  fl, err, miss;
      f  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 15)) : int'($urandom_range(0, 5));
      t  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 15)) : int'($urandom_range(0, 13));
      fl = ($urandom_range(0, 11) == 0);
      max_stall = $urandom_range(0, 3);
      err  = (f >= N) || (t >= N);
      miss = 0;
      v    = err ? 0 : 256 * f + t + 1;
      if (!err) begin
        hitl = -1;
        for (int j = 0; j < NL; j++) if (mv[j] && mt[j] == f && hitl < 0) hitl = j;
        if (hitl >= 0) mh++;
        else begin
          int vic;
          miss = 1;
          mm++;
          vic = -1;
          for (int j = 0; j < NL; j++) if (!mv[j] && vic < 0) vic = j;
          if (vic < 0) begin vic = mp; mp = (mp + 1) % NL; end
          mv[vic] = 1;
          mt[vic] = f;
        end
      end
      txn($sformatf("rnd%0d", i), f, t, fl, 16'(v), err, miss, mh, mm);
      if (fl) begin
        for (int j = 0; j < NL; j++) mv[j] = 0;
        mp = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
